// File: rtl/cache_fsm_if.sv
// Processor-side request/response bundle of the cache controller.
// The master drives a request; the slave (cache_fsm) answers it.
interface cache_fsm_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        Err;

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, Done, Stall, CacheHit, Err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, Done, Stall, CacheHit, Err
    );
endinterface

// File: rtl/cache_fsm.sv
// Write-back cache controller: serves hits in the request cycle, writes back a
// dirty victim line (WB), refills the line from memory (FILL), then replays
// the latched request against the refilled line (RETRY).
module cache_fsm #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    cache_fsm_if.slave  cpu,
    // cache array
    output logic        c_enable,
    output logic [7:0]  c_index,
    output logic [2:0]  c_offset,
    output logic        c_comp,
    output logic        c_write,
    output logic [4:0]  c_tag_out,
    output logic [15:0] c_data_in,
    output logic        c_valid_in,
    input  logic        c_hit,
    input  logic        c_dirty,
    input  logic        c_valid,
    input  logic [4:0]  c_tag_in,
    input  logic [15:0] c_data_out,
    // memory
    output logic [15:0] m_addr,
    output logic [15:0] m_data_in,
    output logic        m_wr,
    output logic        m_rd,
    input  logic [15:0] m_data_out,
    input  logic        m_stall
);

    // ERR is never entered from a legal state; it parks any corrupted encoding back in IDLE.
    typedef enum logic [2:0] {IDLE, WB, FILL, RETRY, ERR} stateType;

    // One outstanding-read slot: which line word will arrive when this slot reaches the end.
    typedef struct packed {
        logic       valid;
        logic [1:0] word;
    } pendEntry;

    stateType    state, stateNext;
    logic [15:0] reqAddr;
    logic [15:0] reqData;
    logic        reqRd;
    logic        reqWr;
    logic [4:0]  victimTag;
    logic [1:0]  wbWord;
    logic [2:0]  issueCnt;     // reads issued so far in FILL; bit 2 set means all four are out
    pendEntry    pend [MEM_LAT];
    pendEntry    installEntry;

    logic        missAccept;
    logic        wbAdvance;
    logic        issueAccept;

    // State register, latched request, write-back/issue counters and the read-return tracker.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            reqAddr   <= '0;
            reqData   <= '0;
            reqRd     <= 1'b0;
            reqWr     <= 1'b0;
            victimTag <= '0;
            wbWord    <= '0;
            issueCnt  <= '0;
            // NOTE: the tracker is a handful of control flops, not a RAM, so it is cleared
            // here; that is what makes data returning after an aborted fill harmless.
            for (int i = 0; i < MEM_LAT; i++) pend[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values,
            // so the shift chain below moves exactly one stage per clock.
            state <= stateNext;
            if (missAccept) begin
                reqAddr   <= cpu.Addr;
                reqData   <= cpu.DataIn;
                reqRd     <= cpu.Rd;
                reqWr     <= cpu.Wr;
                victimTag <= c_tag_in;
                wbWord    <= '0;
                issueCnt  <= '0;
            end
            if (wbAdvance)   wbWord   <= wbWord + 2'd1;
            if (issueAccept) issueCnt <= issueCnt + 3'd1;
            pend[0] <= '{valid: issueAccept, word: issueCnt[1:0]};
            for (int i = 1; i < MEM_LAT; i++) pend[i] <= pend[i-1];
        end
    end

    // Next-state selection and all cache/memory/processor outputs; everything is forced low in reset.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        stateNext    = state;
        missAccept   = 1'b0;
        wbAdvance    = 1'b0;
        issueAccept  = 1'b0;
        installEntry = pend[MEM_LAT-1];
        cpu.DataOut  = '0;
        cpu.Done     = 1'b0;
        cpu.Stall    = 1'b0;
        cpu.CacheHit = 1'b0;
        cpu.Err      = 1'b0;
        c_enable     = 1'b0;
        c_index      = '0;
        c_offset     = '0;
        c_comp       = 1'b0;
        c_write      = 1'b0;
        c_tag_out    = '0;
        c_data_in    = '0;
        c_valid_in   = 1'b0;
        m_addr       = '0;
        m_data_in    = '0;
        m_wr         = 1'b0;
        m_rd         = 1'b0;

        if (rst) begin
            case (state)
                IDLE: begin
                    if (cpu.Rd && cpu.Wr) begin
                        cpu.Err = 1'b1;
                    end else if (cpu.Rd ^ cpu.Wr) begin
                        c_enable   = 1'b1;
                        c_comp     = 1'b1;
                        c_write    = cpu.Wr;
                        c_index    = cpu.Addr[10:3];
                        c_offset   = cpu.Addr[2:0];
                        c_tag_out  = cpu.Addr[15:11];
                        c_data_in  = cpu.DataIn;
                        c_valid_in = cpu.Wr;
                        if (c_hit && c_valid) begin
                            cpu.Done     = 1'b1;
                            cpu.CacheHit = 1'b1;
                            cpu.DataOut  = c_data_out;
                        end else begin
                            missAccept = 1'b1;
                            stateNext  = (c_valid && c_dirty) ? WB : FILL;
                        end
                    end
                end

                WB: begin
                    cpu.Stall = 1'b1;
                    c_enable  = 1'b1;
                    c_index   = reqAddr[10:3];
                    c_offset  = {wbWord, 1'b0};
                    m_wr      = 1'b1;
                    m_addr    = {victimTag, reqAddr[10:3], wbWord, 1'b0};
                    m_data_in = c_data_out;
                    if (!m_stall) begin
                        wbAdvance = 1'b1;
                        if (wbWord == 2'd3) stateNext = FILL;
                    end
                end

                FILL: begin
                    cpu.Stall = 1'b1;
                    if (!issueCnt[2]) begin
                        m_rd   = 1'b1;
                        m_addr = {reqAddr[15:11], reqAddr[10:3], issueCnt[1:0], 1'b0};
                        if (!m_stall) issueAccept = 1'b1;
                    end
                    // Installs run alongside issues; a fill-mode write leaves the line clean.
                    if (installEntry.valid) begin
                        c_enable   = 1'b1;
                        c_write    = 1'b1;
                        c_index    = reqAddr[10:3];
                        c_offset   = {installEntry.word, 1'b0};
                        c_tag_out  = reqAddr[15:11];
                        c_data_in  = m_data_out;
                        c_valid_in = 1'b1;
                        if (installEntry.word == 2'd3) stateNext = RETRY;
                    end
                end

                RETRY: begin
                    cpu.Stall   = 1'b1;
                    cpu.Done    = 1'b1;
                    cpu.DataOut = reqRd ? c_data_out : 16'h0000;
                    c_enable    = 1'b1;
                    c_comp      = 1'b1;
                    c_write     = reqWr;
                    c_index     = reqAddr[10:3];
                    c_offset    = reqAddr[2:0];
                    c_tag_out   = reqAddr[15:11];
                    c_data_in   = reqData;
                    c_valid_in  = reqWr;
                    stateNext   = IDLE;
                end

                default: stateNext = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fsm.sv
// Directed bench for cache_fsm: behavioural cache array and fixed-latency
// memory around the controller, hand-computed expected values per scenario.
module tb_cache_fsm;
    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        c_enable, c_comp, c_write, c_valid_in;
    logic [7:0]  c_index;
    logic [2:0]  c_offset;
    logic [4:0]  c_tag_out;
    logic [15:0] c_data_in;
    logic        c_hit, c_dirty, c_valid;
    logic [4:0]  c_tag_in;
    logic [15:0] c_data_out;
    logic [15:0] m_addr, m_data_in, m_data_out;
    logic        m_wr, m_rd;
    logic        mStall;

    cache_fsm_if cpuIf ();

    cache_fsm #(.MEM_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpuIf.slave),
        .c_enable   (c_enable),
        .c_index    (c_index),
        .c_offset   (c_offset),
        .c_comp     (c_comp),
        .c_write    (c_write),
        .c_tag_out  (c_tag_out),
        .c_data_in  (c_data_in),
        .c_valid_in (c_valid_in),
        .c_hit      (c_hit),
        .c_dirty    (c_dirty),
        .c_valid    (c_valid),
        .c_tag_in   (c_tag_in),
        .c_data_out (c_data_out),
        .m_addr     (m_addr),
        .m_data_in  (m_data_in),
        .m_wr       (m_wr),
        .m_rd       (m_rd),
        .m_data_out (m_data_out),
        .m_stall    (mStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int reqCyc;
    int exclViol = 0;
    int hitViol  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- cache array model ----------------
    bit [4:0]  cTag   [256];
    bit        cValid [256];
    bit        cDirty [256];
    bit [15:0] cData  [256][4];

    logic        plEn = 1'b0;
    logic [7:0]  plIdx;
    logic [4:0]  plTag;
    logic        plValid, plDirty;
    logic [15:0] plWords [4];

    assign c_valid    = cValid[c_index];
    assign c_dirty    = cDirty[c_index];
    assign c_tag_in   = cTag[c_index];
    assign c_data_out = cData[c_index][c_offset[2:1]];
    assign c_hit      = c_comp && cValid[c_index] && (cTag[c_index] == c_tag_out);

    always @(posedge clk) begin
        if (plEn) begin
            cTag[plIdx]   <= plTag;
            cValid[plIdx] <= plValid;
            cDirty[plIdx] <= plDirty;
            for (int w = 0; w < 4; w++) cData[plIdx][w] <= plWords[w];
        end else if (c_enable && c_write) begin
            if (c_comp) begin
                if (c_hit) begin
                    cData[c_index][c_offset[2:1]] <= c_data_in;
                    cDirty[c_index] <= 1'b1;
                end
            end else begin
                cData[c_index][c_offset[2:1]] <= c_data_in;
                cTag[c_index]   <= c_tag_out;
                cValid[c_index] <= c_valid_in;
                cDirty[c_index] <= 1'b0;
            end
        end
    end

    // ---------------- memory model ----------------
    bit [15:0]   mem  [65536];
    bit          memW [65536];
    logic        rdV [LAT];
    logic [15:0] rdA [LAT];

    function automatic logic [15:0] pattern(input logic [15:0] a);
        return a + 16'h1224;
    endfunction

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            rdV[i] <= rdV[i-1];
            rdA[i] <= rdA[i-1];
        end
        rdV[0] <= m_rd && !mStall;
        rdA[0] <= m_addr;
        if (m_wr && !mStall) begin
            mem[m_addr]  <= m_data_in;
            memW[m_addr] <= 1'b1;
        end
    end

    always_comb begin
        m_data_out = 16'h0000;
        if (rdV[LAT-1] === 1'b1)
            m_data_out = memW[rdA[LAT-1]] ? mem[rdA[LAT-1]] : pattern(rdA[LAT-1]);
    end

    // ---------------- bus monitor ----------------
    logic [15:0] rdAddrQ [$];
    int          rdCycQ  [$];
    logic [15:0] wrAddrQ [$];
    logic [15:0] wrDataQ [$];
    int          wrCycQ  [$];

    always @(negedge clk) begin
        if (m_rd && m_wr) exclViol++;
        if (cpuIf.CacheHit && !cpuIf.Done) hitViol++;
        if (rst && m_rd && !mStall) begin
            rdAddrQ.push_back(m_addr);
            rdCycQ.push_back(cyc);
        end
        if (rst && m_wr && !mStall) begin
            wrAddrQ.push_back(m_addr);
            wrDataQ.push_back(m_data_in);
            wrCycQ.push_back(cyc);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        rdAddrQ.delete();
        rdCycQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        wrCycQ.delete();
    endtask

    task automatic preload(input logic [7:0] idx, input logic [4:0] tag, input logic v, input logic d,
                           input logic [15:0] w0, w1, w2, w3);
        plIdx = idx; plTag = tag; plValid = v; plDirty = d;
        plWords[0] = w0; plWords[1] = w1; plWords[2] = w2; plWords[3] = w3;
        plEn = 1'b1;
        nextCycle();
        plEn = 1'b0;
    endtask

    task automatic hitReq(input string tag, input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] data, input logic [15:0] expData);
        cpuIf.Rd = rd; cpuIf.Wr = wr; cpuIf.Addr = addr; cpuIf.DataIn = data;
        #3;
        check({tag, "_stall"}, cpuIf.Stall, 0);
        check({tag, "_done"}, cpuIf.Done, 1);
        check({tag, "_hit"}, cpuIf.CacheHit, 1);
        if (rd) check({tag, "_data"}, cpuIf.DataOut, expData);
        nextCycle();
        cpuIf.Rd = 1'b0; cpuIf.Wr = 1'b0;
    endtask

    task automatic runMiss(input string tag, input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [15:0] data, input int expLat, input logic [15:0] expData,
                           input int stallAt, input int stallLen, input logic [15:0] stallAddr);
        int lat;
        logic done;
        clearLogs();
        reqCyc = cyc;
        cpuIf.Rd = rd; cpuIf.Wr = wr; cpuIf.Addr = addr; cpuIf.DataIn = data;
        #3;
        check({tag, "_req_done"}, cpuIf.Done, 0);
        check({tag, "_req_stall"}, cpuIf.Stall, 0);
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            nextCycle();
            lat++;
            // Junk on the request pins while stalled must be ignored.
            cpuIf.Rd = 1'b1; cpuIf.Wr = 1'b1; cpuIf.Addr = 16'hFFFF; cpuIf.DataIn = 16'h0BAD;
            mStall = (lat >= stallAt) && (lat < stallAt + stallLen);
            #3;
            if (mStall) begin
                check({tag, "_held_rd"}, m_rd, 1);
                check({tag, "_held_addr"}, m_addr, stallAddr);
            end
            done = cpuIf.Done;
        end
        mStall = 1'b0;
        check({tag, "_latency"}, lat, expLat);
        check({tag, "_cachehit"}, cpuIf.CacheHit, 0);
        check({tag, "_stall_at_done"}, cpuIf.Stall, 1);
        if (rd) check({tag, "_data"}, cpuIf.DataOut, expData);
        nextCycle();
        cpuIf.Rd = 1'b0; cpuIf.Wr = 1'b0;
    endtask

    task automatic checkReads(input string tag, input logic [15:0] base, input int firstCyc);
        check({tag, "_rd_count"}, rdAddrQ.size(), 4);
        for (int i = 0; i < 4 && i < rdAddrQ.size(); i++) begin
            check({tag, "_rd_addr"}, rdAddrQ[i], base + 16'(2 * i));
            if (firstCyc >= 0) check({tag, "_rd_cycle"}, rdCycQ[i] - reqCyc, firstCyc + i);
        end
    endtask

    task automatic checkWrites(input string tag, input logic [15:0] base, input int firstCyc);
        check({tag, "_wr_count"}, wrAddrQ.size(), 4);
        for (int i = 0; i < 4 && i < wrAddrQ.size(); i++) begin
            check({tag, "_wr_addr"}, wrAddrQ[i], base + 16'(2 * i));
            check({tag, "_wr_cycle"}, wrCycQ[i] - reqCyc, firstCyc + i);
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rst = 1'b0;
        mStall = 1'b0;
        cpuIf.Rd = 1'b0; cpuIf.Wr = 1'b0; cpuIf.Addr = '0; cpuIf.DataIn = '0;
        #1;
        // A request during reset must not reach the cache or memory.
        cpuIf.Rd = 1'b1; cpuIf.Addr = 16'h1894;
        #3;
        check("reset_ctrl", {cpuIf.Stall, cpuIf.Done, cpuIf.CacheHit, cpuIf.Err,
                             c_enable, c_write, c_comp, m_rd, m_wr}, 0);
        check("reset_maddr", m_addr, 0);
        check("reset_cindex", c_index, 0);
        check("reset_dataout", cpuIf.DataOut, 0);
        preload(8'h12, 5'h03, 1'b1, 1'b0, 16'h0000, 16'h1111, 16'hBEEF, 16'h3333);
        preload(8'h00, 5'h01, 1'b1, 1'b1, 16'h1110, 16'h1111, 16'h1112, 16'h1113);

        // Hit in the very first cycle after reset release.
        rst = 1'b1;
        hitReq("hit", 1'b1, 1'b0, 16'h1894, 16'h0000, 16'hBEEF);

        // Rd and Wr together: error pulse only.
        cpuIf.Rd = 1'b1; cpuIf.Wr = 1'b1; cpuIf.Addr = 16'h0010;
        #3;
        check("err_pulse", cpuIf.Err, 1);
        check("err_no_cache", c_enable, 0);
        check("err_no_mem", {m_rd, m_wr}, 0);
        check("err_no_done", cpuIf.Done, 0);
        nextCycle();
        cpuIf.Rd = 1'b0; cpuIf.Wr = 1'b0;
        #3;
        check("err_single_cycle", cpuIf.Err, 0);
        check("err_stays_idle", cpuIf.Stall, 0);
        nextCycle();

        // Clean miss, then a back-to-back hit on the refilled line.
        runMiss("clean", 1'b1, 1'b0, 16'h0010, 16'h0000, 7, 16'h1234, 0, 0, 16'h0000);
        checkReads("clean", 16'h0010, 1);
        check("clean_no_wb", wrAddrQ.size(), 0);
        hitReq("b2b", 1'b1, 1'b0, 16'h0012, 16'h0000, 16'h1236);
        hitReq("whit", 1'b0, 1'b1, 16'h0014, 16'h5555, 16'h0000);
        hitReq("rhit", 1'b1, 1'b0, 16'h0014, 16'h0000, 16'h5555);

        // Clean miss with memory stalling the second read for three cycles.
        runMiss("mstall", 1'b1, 1'b0, 16'h0026, 16'h0000, 10, 16'h124A, 2, 3, 16'h0022);
        checkReads("mstall", 16'h0020, -1);

        // Dirty write miss: write-back of tag 1 line, refill, then the write lands.
        runMiss("dirty", 1'b0, 1'b1, 16'h1000, 16'hAAAA, 11, 16'h0000, 0, 0, 16'h0000);
        checkWrites("dirty", 16'h0800, 1);
        for (int i = 0; i < 4 && i < wrDataQ.size(); i++)
            check("dirty_wb_data", wrDataQ[i], 16'h1110 + 16'(i));
        checkReads("dirty", 16'h1000, 5);
        hitReq("dirty_follow", 1'b1, 1'b0, 16'h1000, 16'h0000, 16'hAAAA);

        // Reset in cycle 5 of a dirty miss, then the same miss serviced from scratch.
        reqCyc = cyc;
        cpuIf.Rd = 1'b1; cpuIf.Addr = 16'h2800;
        for (int i = 1; i <= 5; i++) begin
            nextCycle();
            cpuIf.Rd = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("abort_ctrl", {cpuIf.Stall, cpuIf.Done, cpuIf.CacheHit, cpuIf.Err,
                             c_enable, c_write, c_comp, m_rd, m_wr}, 0);
        check("abort_maddr", m_addr, 0);
        check("abort_dataout", cpuIf.DataOut, 0);
        nextCycle();
        rst = 1'b1;
        runMiss("postrst", 1'b1, 1'b0, 16'h2800, 16'h0000, 11, 16'h3A24, 0, 0, 16'h0000);
        checkWrites("postrst", 16'h1000, 1);
        if (wrDataQ.size() > 1) begin
            check("postrst_wb_w0", wrDataQ[0], 16'hAAAA);
            check("postrst_wb_w1", wrDataQ[1], 16'h2226);
        end
        checkReads("postrst", 16'h2800, 5);
        hitReq("postrst_follow", 1'b1, 1'b0, 16'h2802, 16'h0000, 16'h3A26);

        check("rd_wr_exclusive", exclViol, 0);
        check("hit_implies_done", hitViol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_fsm.md
CACHE_FSM -- requirements
Module: cache_fsm

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, memory read latency in cycles from accepted m_rd to valid m_data_out.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports Addr in 16, DataIn in 16, Rd in 1, Wr in 1; these are the processor request inputs.
REQ-005 SHALL have ports DataOut out 16, Done out 1, Stall out 1, CacheHit out 1, Err out 1; these are the processor responses.
REQ-006 SHALL have cache-array outputs: c_enable 1, c_index 8, c_offset 3, c_comp 1, c_write 1, c_tag_out 5, c_data_in 16, c_valid_in 1.
REQ-007 SHALL have cache-array inputs: c_hit 1, c_dirty 1, c_valid 1, c_tag_in 5, c_data_out 16.
REQ-008 SHALL have memory ports: m_addr out 16, m_data_in out 16, m_wr out 1, m_rd out 1, m_data_out in 16, m_stall in 1.

Function
REQ-009 SHALL split the address as tag=Addr[15:11], index=Addr[10:3], offset=Addr[2:0], with 4 words per line at offsets 0,2,4,6.
REQ-010 SHALL implement states IDLE, WB (4 word writes), FILL (4 reads plus installs), RETRY, and ERR.
REQ-011 In IDLE, a request (Rd xor Wr) SHALL drive c_enable=1 and c_comp=1, with c_write=Wr, in the same cycle.
REQ-012 If c_hit and c_valid are both 1 in the request cycle, SHALL assert Done=1 and CacheHit=1 combinationally, return DataOut=c_data_out, keep Stall=0, and remain in IDLE.
REQ-013 On a miss, SHALL latch Addr, DataIn, Rd, and Wr, then assert Stall=1 from the next cycle until the Done cycle inclusive; inputs SHALL be ignored while Stall=1.
REQ-014 A miss with c_valid and c_dirty both 1 SHALL go to WB.
- WB SHALL write words 0..3 with m_wr=1, m_addr={victim tag,index,word,1'b0}, m_data_in = cache word read with c_comp=0.
REQ-015 A miss that is not dirty SHALL go to FILL directly.
REQ-016 FILL SHALL issue m_rd for words 0..3 in order.
- Each issue or write SHALL advance only in a cycle with m_stall=0; a stalled request SHALL be held unchanged.
REQ-017 Each FILL word SHALL be installed exactly MEM_LAT cycles after its accepted m_rd: c_comp=0, c_write=1, c_valid_in=1, c_tag_out=latched tag, c_data_in=m_data_out.
- Installs SHALL leave the line clean.
REQ-018 After the last install, RETRY SHALL perform one compare access with the latched op and DataIn.
- In that cycle, Done=1, CacheHit=0, DataOut=c_data_out (reads); then return to IDLE.
REQ-019 Miss latency with m_stall=0 and MEM_LAT=2 SHALL be: clean miss Done exactly 7 cycles after the request cycle; dirty miss exactly 11 cycles after.
REQ-020 Rd=Wr=1 in IDLE SHALL assert Err=1 for that cycle, with no cache or memory access, Done=0, and the FSM staying in IDLE.
REQ-021 Done, CacheHit, and Err SHALL each be single-cycle pulses; CacheHit SHALL never be 1 unless Done=1.
REQ-022 m_rd and m_wr SHALL never both be 1; at most one memory request SHALL be issued per cycle.
REQ-023 Outstanding reads SHALL be tracked with a MEM_LAT-deep shift register of {valid,word}.
- No more than 4 reads SHALL be issued per miss.
REQ-024 After Done, a request arriving in the next cycle SHALL be accepted normally, with no dead cycle.

Reset
REQ-025 While rst=0, SHALL force state=IDLE and clear all latches and the pending-read tracker.
- Stall, Done, CacheHit, Err, c_enable, c_write, c_comp, m_rd, and m_wr SHALL all be 0; data and address outputs SHALL be 0.
REQ-026 Reset asserted mid-WB or mid-FILL SHALL abort immediately, and data returning afterwards SHALL be ignored.
- The cache array contents are not restored by this block.
REQ-027 The first cycle after rst rises SHALL be a legal request cycle.

Verification
REQ-028 Hit: preload line index 0x12 with tag 0x03 valid, word2=0xBEEF; Rd with Addr=0x1894 -> same cycle Done=1, CacheHit=1, DataOut=0xBEEF, Stall=0.
REQ-029 Clean miss: empty cache; Rd with Addr=0x0010 and memory word 0x0010=0x1234 -> m_rd at 0x0010,0x0012,0x0014,0x0016 in cycles 1-4, Done in cycle 7 with DataOut=0x1234, CacheHit=0.
REQ-030 Dirty miss: line index 0 dirty with tag 0x01; Wr with Addr=0x1000, DataIn=0xAAAA -> 4 m_wr to 0x0800-0x0806 first, then 4 m_rd to 0x1000-0x1006, Done in cycle 11, with a follow-up Rd 0x1000 hitting with 0xAAAA.
REQ-031 Memory stall: clean miss with m_stall=1 for 3 cycles on the second read -> m_addr held at word 1 for all 3 cycles, Done delayed exactly 3 cycles to cycle 10.
REQ-032 Error and reset: Rd=Wr=1 -> Err=1 with no c_enable and no m_* activity; a later rst pulse in cycle 5 of a dirty miss -> all outputs 0 the same cycle, and the next request is serviced correctly.
